// File: rtl/datapath_pkg.sv
// Shared encodings for the multi-cycle datapath: ALU opcodes, bus source
// offsets (relative to the first non-GPR code) and iterative-unit FSM states.
package datapath_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_DIV  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SHRA = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_ROR  = 4'd9;
  localparam logic [3:0] OP_ROL  = 4'd10;
  localparam logic [3:0] OP_NEG  = 4'd11;
  localparam logic [3:0] OP_NOT  = 4'd12;

  // Special sources follow the GPR codes in this order.
  localparam int SRC_HI    = 0;
  localparam int SRC_LO    = 1;
  localparam int SRC_ZHI   = 2;
  localparam int SRC_ZLO   = 3;
  localparam int SRC_PC    = 4;
  localparam int SRC_IR    = 5;
  localparam int SRC_MDR   = 6;
  localparam int SRC_IN    = 7;
  localparam int SRC_CSIGN = 8;
  localparam int SRC_Y     = 9;
  localparam int SRC_MAR   = 10;
  localparam int SRC_NUM_SPECIAL = 11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  function automatic int src_width(input int num_gpr);
    return $clog2(num_gpr + SRC_NUM_SPECIAL);
  endfunction

endpackage

// File: rtl/datapath_mc_mul_div_iter.sv
// Iterative signed multiplier (radix-2 Booth) and restoring divider on
// magnitudes; one bit per cycle, result presented combinationally on o_last.
module mul_div_iter
  import datapath_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_is_div,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_busy,
  output logic              o_last,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W:0]   r_acc;
  logic [DATA_W:0]   r_m;
  logic [DATA_W-1:0] r_q;
  logic              r_qm1;
  logic              r_q_neg;
  logic              r_r_neg;

  logic [DATA_W:0]   w_booth;
  logic [DATA_W:0]   w_trial;
  logic [DATA_W+1:0] w_diff;
  logic              w_fits;
  logic [DATA_W-1:0] w_rem;
  logic [DATA_W-1:0] w_quo;
  logic [DATA_W-1:0] w_a_mag;
  logic [DATA_W-1:0] w_b_mag;
  logic              w_unused;

  assign o_busy = (r_state != ST_IDLE);
  assign o_last = o_busy && (r_cnt == CNT_W'(DATA_W - 1));

  assign w_a_mag = i_a[DATA_W-1] ? -i_a : i_a;
  assign w_b_mag = i_b[DATA_W-1] ? -i_b : i_b;

  // Accumulator is one bit wider so adding/subtracting the most-negative
  // multiplicand cannot overflow.
  always_comb begin
    w_booth = r_acc;
    case ({r_q[0], r_qm1})
      2'b01:   w_booth = r_acc + r_m;
      2'b10:   w_booth = r_acc - r_m;
      default: ;
    endcase
  end

  assign w_trial  = {r_acc[DATA_W-1:0], r_q[DATA_W-1]};
  assign w_diff   = {1'b0, w_trial} - {1'b0, r_m};
  assign w_fits   = !w_diff[DATA_W+1];
  assign w_rem    = w_fits ? w_diff[DATA_W-1:0] : w_trial[DATA_W-1:0];
  assign w_quo    = {r_q[DATA_W-2:0], w_fits};
  assign w_unused = w_diff[DATA_W];

  always_comb begin
    if (r_state == ST_DIV) begin
      o_hi = r_r_neg ? -w_rem : w_rem;
      o_lo = r_q_neg ? -w_quo : w_quo;
    end else begin
      o_hi = w_booth[DATA_W:1];
      o_lo = {w_booth[0], r_q[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_qm1   <= 1'b0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
    end else if (o_busy) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (o_last) r_state <= ST_IDLE;
      if (r_state == ST_DIV) begin
        r_acc <= {1'b0, w_rem};
        r_q   <= w_quo;
      end else begin
        r_acc <= {w_booth[DATA_W], w_booth[DATA_W:1]};
        r_q   <= {w_booth[0], r_q[DATA_W-1:1]};
        r_qm1 <= r_q[0];
      end
    end else if (i_start) begin
      r_state <= i_is_div ? ST_DIV : ST_MUL;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_qm1   <= 1'b0;
      r_q     <= i_is_div ? w_a_mag : i_b;
      r_m     <= i_is_div ? {1'b0, w_b_mag} : {i_a[DATA_W-1], i_a};
      r_q_neg <= i_a[DATA_W-1] ^ i_b[DATA_W-1];
      r_r_neg <= i_a[DATA_W-1];
    end
  end

endmodule

// File: rtl/datapath_mc.sv
// Single-bus multi-cycle datapath: GPR bank, special registers, encoded bus
// mux, single-cycle ALU and an iterative MUL/DIV unit with start/busy/done.
module datapath_mc
  import datapath_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_GPR = 16,
  parameter int PC_INC  = 1,
  localparam int SRC_W  = src_width(NUM_GPR),
  localparam int GPR_W  = $clog2(NUM_GPR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SRC_W-1:0]  bus_src,
  input  logic              gpr_wr,
  input  logic [GPR_W-1:0]  gpr_sel,
  input  logic              pc_in,
  input  logic              ir_in,
  input  logic              y_in,
  input  logic              mar_in,
  input  logic              mdr_in,
  input  logic              inc_pc,
  input  logic              mdr_read,
  input  logic              hi_in,
  input  logic              lo_in,
  input  logic              hl_from_z,
  input  logic [3:0]        alu_op,
  input  logic              alu_start,
  input  logic [DATA_W-1:0] in_port,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] csign,
  output logic [DATA_W-1:0] bus_out,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] mar,
  output logic [DATA_W-1:0] mdr,
  output logic              busy,
  output logic              done,
  output logic              div_zero
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W-1:0] r_gpr [NUM_GPR];
  logic [DATA_W-1:0] r_hi, r_lo, r_zhi, r_zlo, r_pc, r_ir, r_y, r_mar, r_mdr;
  logic              r_done, r_div_zero;

  logic [DATA_W-1:0] w_bus, w_alu_lo, w_alu_hi, w_core_hi, w_core_lo;
  logic [SH_W-1:0]   w_sh;
  logic              w_accept, w_core_start, w_div_by_zero, w_core_busy, w_core_last;

  always_comb begin
    w_bus = '0;
    if (int'(bus_src) < NUM_GPR) begin
      w_bus = r_gpr[bus_src[GPR_W-1:0]];
    end else begin
      case (int'(bus_src) - NUM_GPR)
        SRC_HI:    w_bus = r_hi;
        SRC_LO:    w_bus = r_lo;
        SRC_ZHI:   w_bus = r_zhi;
        SRC_ZLO:   w_bus = r_zlo;
        SRC_PC:    w_bus = r_pc;
        SRC_IR:    w_bus = r_ir;
        SRC_MDR:   w_bus = r_mdr;
        SRC_IN:    w_bus = in_port;
        SRC_CSIGN: w_bus = csign;
        SRC_Y:     w_bus = r_y;
        SRC_MAR:   w_bus = r_mar;
        default:   w_bus = '0;
      endcase
    end
  end

  assign w_sh = w_bus[SH_W-1:0];

  always_comb begin
    w_alu_lo = '0;
    w_alu_hi = '0;
    case (alu_op)
      OP_AND:  w_alu_lo = r_y & w_bus;
      OP_OR:   w_alu_lo = r_y | w_bus;
      OP_ADD: begin
        w_alu_lo = r_y + w_bus;
        w_alu_hi = {DATA_W{w_alu_lo[DATA_W-1]}};
      end
      OP_SUB: begin
        w_alu_lo = r_y - w_bus;
        w_alu_hi = {DATA_W{w_alu_lo[DATA_W-1]}};
      end
      OP_DIV: begin
        w_alu_lo = '1;
        w_alu_hi = r_y;
      end
      OP_SHR:  w_alu_lo = r_y >> w_sh;
      OP_SHRA: w_alu_lo = $signed(r_y) >>> w_sh;
      OP_SHL:  w_alu_lo = r_y << w_sh;
      OP_ROR:  w_alu_lo = (r_y >> w_sh) | (r_y << (DATA_W - int'(w_sh)));
      OP_ROL:  w_alu_lo = (r_y << w_sh) | (r_y >> (DATA_W - int'(w_sh)));
      OP_NEG:  w_alu_lo = -w_bus;
      OP_NOT:  w_alu_lo = ~w_bus;
      default: ;
    endcase
  end

  // Divide-by-zero never enters the iterative unit; it completes in one cycle.
  assign w_accept      = alu_start && !w_core_busy;
  assign w_div_by_zero = (alu_op == OP_DIV) && (w_bus == '0);
  assign w_core_start  = w_accept && ((alu_op == OP_MUL) ||
                                      ((alu_op == OP_DIV) && !w_div_by_zero));

  mul_div_iter #(
    .DATA_W (DATA_W)
  ) u_mul_div_iter (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_core_start),
    .i_is_div (alu_op == OP_DIV),
    .i_a      (r_y),
    .i_b      (w_bus),
    .o_busy   (w_core_busy),
    .o_last   (w_core_last),
    .o_hi     (w_core_hi),
    .o_lo     (w_core_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_GPR; i++) r_gpr[i] <= '0;
    end else if (gpr_wr) begin
      r_gpr[gpr_sel] <= w_bus;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_pc  <= '0;
      r_ir  <= '0;
      r_y   <= '0;
      r_mar <= '0;
      r_mdr <= '0;
    end else begin
      if (hi_in)  r_hi  <= hl_from_z ? r_zhi : w_bus;
      if (lo_in)  r_lo  <= hl_from_z ? r_zlo : w_bus;
      if (pc_in)  r_pc  <= inc_pc ? r_pc + DATA_W'(PC_INC) : w_bus;
      if (mar_in) r_mar <= inc_pc ? r_pc : w_bus;
      if (mdr_in) r_mdr <= mdr_read ? mem_rdata : w_bus;
      if (ir_in)  r_ir  <= w_bus;
      if (y_in)   r_y   <= w_bus;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_zhi      <= '0;
      r_zlo      <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_core_busy && w_core_last) begin
        r_zhi  <= w_core_hi;
        r_zlo  <= w_core_lo;
        r_done <= 1'b1;
      end else if (w_accept) begin
        r_div_zero <= w_div_by_zero;
        if (!w_core_start) begin
          r_zhi  <= w_alu_hi;
          r_zlo  <= w_alu_lo;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign bus_out  = w_bus;
  assign pc       = r_pc;
  assign mar      = r_mar;
  assign mdr      = r_mdr;
  assign busy     = w_core_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_datapath_mc.sv
// Directed self-checking bench: vector table for single-cycle ALU ops plus
// hand sequences for MUL/DIV timing, register moves and mid-op reset.
module tb_datapath_mc;

  localparam logic [3:0] A_AND = 4'd0, A_OR = 4'd1, A_ADD = 4'd2, A_SUB = 4'd3,
                         A_MUL = 4'd4, A_DIV = 4'd5, A_SHR = 4'd6, A_SHRA = 4'd7,
                         A_SHL = 4'd8, A_ROR = 4'd9, A_ROL = 4'd10, A_NEG = 4'd11,
                         A_NOT = 4'd12;
  localparam logic [4:0] C_HI = 5'd16, C_LO = 5'd17, C_ZHI = 5'd18, C_ZLO = 5'd19,
                         C_PC = 5'd20, C_IR = 5'd21, C_IN = 5'd23, C_CSIGN = 5'd24,
                         C_Y = 5'd25, C_BAD = 5'd27;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [4:0]  bus_src;
  logic        gpr_wr, pc_in, ir_in, y_in, mar_in, mdr_in, inc_pc, mdr_read;
  logic        hi_in, lo_in, hl_from_z, alu_start;
  logic [3:0]  gpr_sel, alu_op;
  logic [31:0] in_port, mem_rdata, csign, bus_out, pc, mar, mdr;
  logic        busy, done, div_zero;

  logic [4:0]  s_bus_src;
  logic        s_y_in, s_alu_start;
  logic [3:0]  s_alu_op;
  logic [15:0] s_csign, s_bus_out, s_pc, s_mar, s_mdr;
  logic        s_busy, s_done, s_div_zero;

  int checks = 0;
  int errors = 0;
  vec_t vecs [13];

  datapath_mc dut (
    .clk(clk), .reset(reset), .bus_src(bus_src), .gpr_wr(gpr_wr), .gpr_sel(gpr_sel),
    .pc_in(pc_in), .ir_in(ir_in), .y_in(y_in), .mar_in(mar_in), .mdr_in(mdr_in),
    .inc_pc(inc_pc), .mdr_read(mdr_read), .hi_in(hi_in), .lo_in(lo_in),
    .hl_from_z(hl_from_z), .alu_op(alu_op), .alu_start(alu_start),
    .in_port(in_port), .mem_rdata(mem_rdata), .csign(csign), .bus_out(bus_out),
    .pc(pc), .mar(mar), .mdr(mdr), .busy(busy), .done(done), .div_zero(div_zero)
  );

  datapath_mc #(.DATA_W(16), .NUM_GPR(8)) dut_small (
    .clk(clk), .reset(reset), .bus_src(s_bus_src), .gpr_wr(1'b0), .gpr_sel(3'd0),
    .pc_in(1'b0), .ir_in(1'b0), .y_in(s_y_in), .mar_in(1'b0), .mdr_in(1'b0),
    .inc_pc(1'b0), .mdr_read(1'b0), .hi_in(1'b0), .lo_in(1'b0),
    .hl_from_z(1'b0), .alu_op(s_alu_op), .alu_start(s_alu_start),
    .in_port(16'd0), .mem_rdata(16'd0), .csign(s_csign), .bus_out(s_bus_out),
    .pc(s_pc), .mar(s_mar), .mdr(s_mdr), .busy(s_busy), .done(s_done),
    .div_zero(s_div_zero)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task tick;
    @(posedge clk);
    #1;
  endtask

  task bus_read(input logic [4:0] src, output logic [31:0] v);
    bus_src = src;
    #1;
    v = bus_out;
  endtask

  task load_y(input logic [31:0] v);
    csign = v; bus_src = C_CSIGN; y_in = 1'b1;
    tick;
    y_in = 1'b0;
  endtask

  task start_op(input logic [3:0] op, input logic [31:0] b);
    csign = b; bus_src = C_CSIGN; alu_op = op; alu_start = 1'b1;
    tick;
    alu_start = 1'b0;
  endtask

  // Called just after the start edge (cycle 1); returns the cycle done is seen.
  task run_iter(input logic inject, output int done_cyc, output int busy_cnt,
                output int overlap);
    done_cyc = 0; busy_cnt = 0; overlap = 0;
    for (int c = 1; c <= 60; c++) begin
      if (busy && done) overlap++;
      if (done) begin
        done_cyc = c;
        break;
      end
      if (busy) busy_cnt++;
      if (inject && c == 10) begin
        alu_op = A_ADD; alu_start = 1'b1;
      end else begin
        alu_start = 1'b0;
      end
      tick;
    end
    alu_start = 1'b0;
  endtask

  logic [31:0] v;
  int dc, bc, ov;

  initial begin
    reset = 1'b1; bus_src = '0; gpr_wr = 0; gpr_sel = '0; pc_in = 0; ir_in = 0;
    y_in = 0; mar_in = 0; mdr_in = 0; inc_pc = 0; mdr_read = 0; hi_in = 0;
    lo_in = 0; hl_from_z = 0; alu_op = '0; alu_start = 0; in_port = '0;
    mem_rdata = '0; csign = '0;
    s_bus_src = '0; s_y_in = 0; s_alu_start = 0; s_alu_op = '0; s_csign = '0;

    vecs[0]  = '{A_AND,  32'hF0F01234, 32'h0FF0FF00, 32'h00F01200, 32'h00000000};
    vecs[1]  = '{A_OR,   32'hF0000000, 32'h0000000F, 32'hF000000F, 32'h00000000};
    vecs[2]  = '{A_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'hFFFFFFFF};
    vecs[3]  = '{A_SUB,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 32'hFFFFFFFF};
    vecs[4]  = '{A_SHR,  32'h80000010, 32'h00000004, 32'h08000001, 32'h00000000};
    vecs[5]  = '{A_SHRA, 32'h80000010, 32'h00000004, 32'hF8000001, 32'h00000000};
    vecs[6]  = '{A_SHL,  32'h00000003, 32'h00000023, 32'h00000018, 32'h00000000};
    vecs[7]  = '{A_SHL,  32'h00000003, 32'h0000001F, 32'h80000000, 32'h00000000};
    vecs[8]  = '{A_ROR,  32'h00000001, 32'h00000001, 32'h80000000, 32'h00000000};
    vecs[9]  = '{A_ROL,  32'h80000001, 32'h00000004, 32'h00000018, 32'h00000000};
    vecs[10] = '{A_ROR,  32'h12345678, 32'h00000020, 32'h12345678, 32'h00000000};
    vecs[11] = '{A_NEG,  32'h00000063, 32'h00000005, 32'hFFFFFFFB, 32'h00000000};
    vecs[12] = '{A_NOT,  32'h00000000, 32'h0000FFFF, 32'hFFFF0000, 32'h00000000};

    tick; tick;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_div_zero", 32'(div_zero), 32'd0);
    check("rst_pc", pc, 32'd0);
    bus_read(C_ZLO, v); check("rst_zlo", v, 32'd0);
    reset = 1'b0;
    tick;

    // ADD from a GPR source
    csign = 32'd5; bus_src = C_CSIGN; gpr_sel = 4'd1; gpr_wr = 1'b1;
    tick;
    gpr_wr = 1'b0;
    load_y(32'd7);
    bus_src = 5'd1; alu_op = A_ADD; alu_start = 1'b1;
    tick;
    alu_start = 1'b0;
    check("add_r1_done", 32'(done), 32'd1);
    check("add_r1_busy", 32'(busy), 32'd0);
    bus_read(C_ZLO, v); check("add_r1_zlo", v, 32'd12);
    bus_read(C_ZHI, v); check("add_r1_zhi", v, 32'd0);
    tick;
    check("add_r1_done_drop", 32'(done), 32'd0);
    check("add_r1_busy_after", 32'(busy), 32'd0);

    for (int i = 0; i < 13; i++) begin
      load_y(vecs[i].a);
      start_op(vecs[i].op, vecs[i].b);
      check("vec_done", 32'(done), 32'd1);
      check("vec_busy", 32'(busy), 32'd0);
      bus_read(C_ZLO, v); check("vec_zlo", v, vecs[i].lo);
      bus_read(C_ZHI, v); check("vec_zhi", v, vecs[i].hi);
      $display("vec %0d op=%0d a=%h b=%h zlo=%h", i, vecs[i].op, vecs[i].a, vecs[i].b, v);
      tick;
      check("vec_done_pulse", 32'(done), 32'd0);
    end

    // MUL -3 * 4 with an ignored start at cycle 10
    load_y(32'hFFFFFFFD);
    start_op(A_MUL, 32'd4);
    run_iter(1'b1, dc, bc, ov);
    check("mul_done_cyc", 32'(dc), 32'd33);
    check("mul_busy_cycles", 32'(bc), 32'd32);
    check("mul_overlap", 32'(ov), 32'd0);
    check("mul_busy_at_done", 32'(busy), 32'd0);
    bus_read(C_ZHI, v); check("mul_zhi", v, 32'hFFFFFFFF);
    bus_read(C_ZLO, v); check("mul_zlo", v, 32'hFFFFFFF4);
    $display("mul done_cyc=%0d busy_cycles=%0d", dc, bc);
    hi_in = 1'b1; lo_in = 1'b1; hl_from_z = 1'b1;
    tick;
    hi_in = 1'b0; lo_in = 1'b0; hl_from_z = 1'b0;
    bus_read(C_HI, v); check("hi_from_z", v, 32'hFFFFFFFF);
    bus_read(C_LO, v); check("lo_from_z", v, 32'hFFFFFFF4);

    // DIV -17 / 5, then by zero, then most-negative / -1
    load_y(32'hFFFFFFEF);
    start_op(A_DIV, 32'd5);
    run_iter(1'b0, dc, bc, ov);
    check("div_done_cyc", 32'(dc), 32'd33);
    check("div_overlap", 32'(ov), 32'd0);
    bus_read(C_ZLO, v); check("div_zlo", v, 32'hFFFFFFFD);
    bus_read(C_ZHI, v); check("div_zhi", v, 32'hFFFFFFFE);
    check("div_zero_clear", 32'(div_zero), 32'd0);
    $display("div -17/5 done_cyc=%0d", dc);
    tick;
    start_op(A_DIV, 32'd0);
    check("div0_done", 32'(done), 32'd1);
    check("div0_busy", 32'(busy), 32'd0);
    check("div0_flag", 32'(div_zero), 32'd1);
    bus_read(C_ZLO, v); check("div0_zlo", v, 32'hFFFFFFFF);
    bus_read(C_ZHI, v); check("div0_zhi", v, 32'hFFFFFFEF);
    tick;
    check("div0_sticky", 32'(div_zero), 32'd1);
    start_op(A_AND, 32'd1);
    check("div0_cleared", 32'(div_zero), 32'd0);
    tick;
    load_y(32'h80000000);
    start_op(A_DIV, 32'hFFFFFFFF);
    run_iter(1'b0, dc, bc, ov);
    check("divmin_done_cyc", 32'(dc), 32'd33);
    bus_read(C_ZLO, v); check("divmin_zlo", v, 32'h80000000);
    bus_read(C_ZHI, v); check("divmin_zhi", v, 32'd0);

    // PC/MAR/MDR moves and bus decode
    csign = 32'h10; bus_src = C_CSIGN; pc_in = 1'b1;
    tick;
    check("pc_load", pc, 32'h10);
    inc_pc = 1'b1; mar_in = 1'b1;
    tick;
    pc_in = 1'b0; inc_pc = 1'b0; mar_in = 1'b0;
    check("pc_inc", pc, 32'h11);
    check("mar_from_pc", mar, 32'h10);
    bus_read(C_PC, v); check("bus_pc", v, 32'h11);
    bus_read(C_BAD, v); check("bus_illegal", v, 32'd0);
    in_port = 32'hA5A5A5A5;
    bus_read(C_IN, v); check("bus_in", v, 32'hA5A5A5A5);
    mem_rdata = 32'hCAFEF00D; mdr_in = 1'b1; mdr_read = 1'b1;
    tick;
    mdr_read = 1'b0;
    check("mdr_mem", mdr, 32'hCAFEF00D);
    csign = 32'h55; bus_src = C_CSIGN; ir_in = 1'b1; y_in = 1'b1;
    gpr_sel = 4'd3; gpr_wr = 1'b1;
    tick;
    mdr_in = 1'b0; ir_in = 1'b0; y_in = 1'b0; gpr_wr = 1'b0;
    check("mdr_bus", mdr, 32'h55);
    bus_read(C_IR, v); check("multi_ir", v, 32'h55);
    bus_read(C_Y, v); check("multi_y", v, 32'h55);
    bus_read(5'd3, v); check("multi_r3", v, 32'h55);

    // DATA_W=16, NUM_GPR=8 instance: same MUL case
    s_csign = 16'hFFFD; s_bus_src = 5'd16; s_y_in = 1'b1;
    tick;
    s_y_in = 1'b0; s_csign = 16'd4; s_alu_op = A_MUL; s_alu_start = 1'b1;
    tick;
    s_alu_start = 1'b0;
    dc = 0;
    for (int c = 1; c <= 40; c++) begin
      if (s_done) begin
        dc = c;
        break;
      end
      tick;
    end
    check("s_mul_done_cyc", 32'(dc), 32'd17);
    s_bus_src = 5'd10; #1; check("s_mul_zhi", 32'(s_bus_out), 32'h0000FFFF);
    s_bus_src = 5'd11; #1; check("s_mul_zlo", 32'(s_bus_out), 32'h0000FFF4);
    $display("small mul done_cyc=%0d", dc);
    tick;

    // Reset in the middle of a MUL
    load_y(32'hFFFFFFFD);
    start_op(A_MUL, 32'd4);
    for (int c = 1; c < 15; c++) tick;
    check("rstmid_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_pc", pc, 32'd0);
    check("rstmid_mar", mar, 32'd0);
    check("rstmid_mdr", mdr, 32'd0);
    bus_read(C_ZLO, v); check("rstmid_zlo", v, 32'd0);
    bus_read(C_Y, v); check("rstmid_y", v, 32'd0);
    bus_read(5'd1, v); check("rstmid_r1", v, 32'd0);
    bus_read(C_HI, v); check("rstmid_hi", v, 32'd0);
    tick;
    reset = 1'b0;
    dc = 0;
    for (int c = 0; c < 40; c++) begin
      if (done || busy) dc++;
      tick;
    end
    check("rstmid_no_done", 32'(dc), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath_mc.md
Name: datapath_mc

Overview:
Parametrised multi-cycle successor of the single-bus CPU datapath.
- Keeps the GPR bank, special registers, single shared bus and Z/HI/LO organisation.
- Bus sources are encoded rather than one-hot.
- MUL and DIV become iterative units with a start/busy/done handshake, so the control unit stalls on them instead of relying on a combinational multiplier/divider.
- Sits between the control sequencer and memory/IO ports.

Parameters:
DATA_W, 32, datapath width in bits (power of two, >= 8)
NUM_GPR, 16, number of general-purpose registers (power of two, 2..32)
PC_INC, 1, constant added to PC on inc_pc

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
bus_src  in  SRC_W  bus source: 0..NUM_GPR-1 = GPR; then HI, LO, ZHI, ZLO, PC, IR, MDR, IN, CSIGN, Y, MAR in that order; any other code drives 0
gpr_wr  in  1  write BusMuxOut into GPR gpr_sel
gpr_sel  in  GPR_W  destination GPR index
pc_in, ir_in, y_in, mar_in, mdr_in  in  1 each  load enable for that register
inc_pc  in  1  with pc_in: PC <= PC+PC_INC; with mar_in: MAR <= PC
mdr_read  in  1  with mdr_in: MDR <= mem_rdata, else MDR <= BusMuxOut
hi_in, lo_in  in  1 each  load HI/LO
hl_from_z  in  1  HI/LO source: 1 = ZHI/ZLO, 0 = BusMuxOut
alu_op  in  4  0 AND,1 OR,2 ADD,3 SUB,4 MUL,5 DIV,6 SHR,7 SHRA,8 SHL,9 ROR,10 ROL,11 NEG,12 NOT; 13-15 reserved
alu_start  in  1  start operation alu_op on operands A=Y, B=BusMuxOut
in_port, mem_rdata, csign  in  DATA_W each  external IN, memory read data, sign-extended constant
bus_out  out  DATA_W  BusMuxOut
pc, mar, mdr  out  DATA_W each  register values for the memory interface
busy  out  1  iterative op in progress
done  out  1  one-cycle pulse: Z holds a new result
div_zero  out  1  sticky until the next alu_start; last DIV had divisor 0

Behaviour:
- SRC_W = clog2(NUM_GPR+11); GPR_W = clog2(NUM_GPR).
- Reset (asynchronous): all registers 0, FSM to IDLE, busy=0, done=0, div_zero=0. An in-flight MUL/DIV is aborted with no write to Z.
- Register loads occur at the edge where their enable is high. Several enables in one cycle all load the same bus value.
- PC mux precedence: inc_pc over bus.
- FSM IDLE/MUL/DIV:
  - alu_start in IDLE latches A, B and op.
  - alu_start while busy=1 is ignored.
- Single-cycle ops (0-3, 6-13):
  - Z updated at the start edge; done=1 for the following cycle; busy stays 0.
  - ZHI=0, except ADD/SUB, where ZHI = sign-extension of ZLO.
- ADD/SUB: modulo 2^DATA_W. NEG = 0-B. NOT = ~B. NEG and NOT ignore A.
- Shifts and rotates: amount = B[clog2(DATA_W)-1:0]; operand is A; SHRA replicates A[DATA_W-1].
- MUL:
  - Signed DATA_W x DATA_W -> 2*DATA_W, radix-2 Booth.
  - busy=1 from the cycle after the start edge.
  - {ZHI,ZLO} written at start edge + DATA_W; done pulses the next cycle, busy falls together with done rising.
- DIV:
  - Signed restoring division on magnitudes. Quotient to ZLO, truncated toward zero; remainder to ZHI, with the sign of the dividend.
  - Same latency as MUL.
  - B==0: completes like a single-cycle op, ZLO = all ones, ZHI = A, div_zero=1.
  - Most-negative / -1: ZLO = most-negative, ZHI=0.
- done and busy are never high together.
- Z is never written while busy=1 except at completion.
- HI/LO with hl_from_z=1 sample the current Z registers; the sequencer issues this after done.

Decomposition:
- Shared package datapath_pkg: alu_op encodings, bus_src encodings and index constants, FSM state enum.
- One sub-module, mul_div_iter: the iterative Booth/restoring core with start/done. The top level holds the registers, bus mux and single-cycle ALU.

Test Plan:
- Defaults (DATA_W=32). Y=7, bus_src=R1 (R1=5), ADD start -> ZLO=12, ZHI=0, done exactly 1 cycle after start, busy never high.
- Y=-3, bus=4, MUL -> done exactly 33 cycles after start edge, ZHI=0xFFFFFFFF, ZLO=0xFFFFFFF4; second alu_start at cycle 10 ignored.
- Y=-17, bus=5, DIV -> ZLO=0xFFFFFFFD, ZHI=0xFFFFFFFE, div_zero=0. Then bus=0 DIV -> 1-cycle done, ZLO=0xFFFFFFFF, ZHI=0xFFFFFFEF, div_zero=1.
- MUL started, reset asserted at cycle 15 -> busy=0 and all registers 0 immediately; no done pulse afterwards.
- PC=0x10, pc_in+inc_pc+mar_in -> PC=0x11, MAR=0x10. bus_src=PC code -> bus_out=0x11. Illegal bus_src -> bus_out=0.
- After MUL above, hi_in+lo_in+hl_from_z -> HI=0xFFFFFFFF, LO=0xFFFFFFF4. Parameter run DATA_W=16, NUM_GPR=8 repeats the MUL case: 17-cycle done, {ZHI,ZLO}=0xFFFF_FFF4.
